// File: rtl/operand_loader_if.sv
// rtl/operand_loader_if.sv - Descriptor, operand stream, SRAM write port and MAC handshake bundle
// for operand_loader. The slave modport is the loader's view; master is the environment's view.
interface operand_loader_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 3
);
    logic              cfg_valid;
    logic [11:0]       cfg_mnt;
    logic              cfg_ready;

    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;

    logic              we_i;
    logic [ADDR_W-1:0] waddr_i;
    logic [DATA_W-1:0] wdata_i;
    logic              we_w;
    logic [ADDR_W-1:0] waddr_w;
    logic [DATA_W-1:0] wdata_w;

    logic              start;
    logic [11:0]       mnt;
    logic              done;
    logic              busy;
    logic              err;

    modport master (
        output cfg_valid, cfg_mnt, s_valid, s_data, done,
        input  cfg_ready, s_ready, we_i, waddr_i, wdata_i,
               we_w, waddr_w, wdata_w, start, mnt, busy, err
    );

    modport slave (
        input  cfg_valid, cfg_mnt, s_valid, s_data, done,
        output cfg_ready, s_ready, we_i, waddr_i, wdata_i,
               we_w, waddr_w, wdata_w, start, mnt, busy, err
    );
endinterface

// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - Loads T input and M weight words into the SRAMs, then starts the MAC array.
// Define LOADER_ZERO_FILL_EN to zero-pad unused SRAM words (PAD state) before START.
module operand_loader #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    operand_loader_if.slave bus
);
    localparam int CW = ADDR_W + 1;

`ifdef LOADER_ZERO_FILL_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD_I, S_LOAD_W, S_FIRE, S_WAIT, S_PAD} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD_I, S_LOAD_W, S_FIRE, S_WAIT} state_t;
`endif

    state_t            r_state;
    state_t            w_next_state;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_next_cnt;
    logic [CW-1:0]     w_cnt_inc;
    logic [CW-1:0]     w_job_m;
    logic [CW-1:0]     w_job_t;

    logic              r_cfg_ready;
    logic              r_s_ready;
    logic              r_busy;
    logic              r_start;
    logic              r_err;
    logic              r_we_i;
    logic              r_we_w;
    logic [ADDR_W-1:0] r_waddr_i;
    logic [ADDR_W-1:0] r_waddr_w;
    logic [DATA_W-1:0] r_wdata_i;
    logic [DATA_W-1:0] r_wdata_w;
    logic [11:0]       r_mnt;

    logic              w_cfg_hs;
    logic              w_s_hs;
    logic              w_cfg_ok;
    logic              w_latch;
    logic              w_err;
    logic              w_we_i;
    logic              w_we_w;
    logic [DATA_W-1:0] w_wdata;
    logic [3:0]        w_cfg_m;
    logic [3:0]        w_cfg_n;
    logic [3:0]        w_cfg_t;

`ifdef LOADER_ZERO_FILL_EN
    logic              r_pad_w;
    logic              w_next_pad_w;
`endif

    assign w_cfg_hs  = bus.cfg_valid & r_cfg_ready;
    assign w_s_hs    = bus.s_valid & r_s_ready;
    assign w_cfg_m   = bus.cfg_mnt[11:8];
    assign w_cfg_n   = bus.cfg_mnt[7:4];
    assign w_cfg_t   = bus.cfg_mnt[3:0];
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_job_m   = CW'(r_mnt[11:8]);
    assign w_job_t   = CW'(r_mnt[3:0]);

    assign w_cfg_ok = (w_cfg_m != 4'd0) && ({1'b0, w_cfg_m} <= 5'(DEPTH)) &&
                      (w_cfg_n != 4'd0) && (w_cfg_n <= 4'd4) &&
                      (w_cfg_t != 4'd0) && ({1'b0, w_cfg_t} <= 5'(DEPTH));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_we_i       = 1'b0;
        w_we_w       = 1'b0;
        w_wdata      = bus.s_data;
        w_latch      = 1'b0;
        w_err        = 1'b0;
`ifdef LOADER_ZERO_FILL_EN
        w_next_pad_w = r_pad_w;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_cfg_hs) begin
                    if (w_cfg_ok) begin
                        w_latch      = 1'b1;
                        w_next_cnt   = '0;
                        w_next_state = S_LOAD_I;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            S_LOAD_I: begin
                if (w_s_hs) begin
                    w_we_i = 1'b1;
                    if (w_cnt_inc == w_job_t) begin
                        w_next_cnt   = '0;
                        w_next_state = S_LOAD_W;
                    end else begin
                        w_next_cnt = w_cnt_inc;
                    end
                end
            end
            S_LOAD_W: begin
                if (w_s_hs) begin
                    w_we_w = 1'b1;
                    if (w_cnt_inc == w_job_m) begin
`ifdef LOADER_ZERO_FILL_EN
                        // Pad the input SRAM first, then the weight SRAM; a full SRAM is skipped.
                        if (w_job_t < CW'(DEPTH)) begin
                            w_next_cnt   = w_job_t;
                            w_next_pad_w = 1'b0;
                            w_next_state = S_PAD;
                        end else if (w_job_m < CW'(DEPTH)) begin
                            w_next_cnt   = w_job_m;
                            w_next_pad_w = 1'b1;
                            w_next_state = S_PAD;
                        end else begin
                            w_next_cnt   = '0;
                            w_next_state = S_FIRE;
                        end
`else
                        w_next_cnt   = '0;
                        w_next_state = S_FIRE;
`endif
                    end else begin
                        w_next_cnt = w_cnt_inc;
                    end
                end
            end
`ifdef LOADER_ZERO_FILL_EN
            S_PAD: begin
                w_wdata = '0;
                if (r_pad_w) begin
                    w_we_w = 1'b1;
                end else begin
                    w_we_i = 1'b1;
                end
                if (r_cnt == CW'(DEPTH - 1)) begin
                    if (!r_pad_w && (w_job_m < CW'(DEPTH))) begin
                        w_next_cnt   = w_job_m;
                        w_next_pad_w = 1'b1;
                    end else begin
                        w_next_cnt   = '0;
                        w_next_state = S_FIRE;
                    end
                end else begin
                    w_next_cnt = w_cnt_inc;
                end
            end
`endif
            S_FIRE: begin
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (bus.done) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Every output is a register loaded from the next-state decode, so each
    // status flag lines up with the state it describes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt       <= '0;
            r_cfg_ready <= 1'b0;
            r_s_ready   <= 1'b0;
            r_busy      <= 1'b0;
            r_start     <= 1'b0;
            r_err       <= 1'b0;
            r_we_i      <= 1'b0;
            r_we_w      <= 1'b0;
            r_waddr_i   <= '0;
            r_waddr_w   <= '0;
            r_wdata_i   <= '0;
            r_wdata_w   <= '0;
            r_mnt       <= '0;
`ifdef LOADER_ZERO_FILL_EN
            r_pad_w     <= 1'b0;
`endif
        end else begin
            r_cnt       <= w_next_cnt;
            r_cfg_ready <= (w_next_state == S_IDLE);
            r_s_ready   <= (w_next_state == S_LOAD_I) || (w_next_state == S_LOAD_W);
            r_busy      <= (w_next_state != S_IDLE);
            r_start     <= (w_next_state == S_FIRE);
            r_err       <= w_err;
            r_we_i      <= w_we_i;
            r_we_w      <= w_we_w;
            if (w_we_i) begin
                r_waddr_i <= r_cnt[ADDR_W-1:0];
                r_wdata_i <= w_wdata;
            end
            if (w_we_w) begin
                r_waddr_w <= r_cnt[ADDR_W-1:0];
                r_wdata_w <= w_wdata;
            end
            if (w_latch) begin
                r_mnt <= bus.cfg_mnt;
            end
`ifdef LOADER_ZERO_FILL_EN
            r_pad_w     <= w_next_pad_w;
`endif
        end
    end

    assign bus.cfg_ready = r_cfg_ready;
    assign bus.s_ready   = r_s_ready;
    assign bus.busy      = r_busy;
    assign bus.start     = r_start;
    assign bus.err       = r_err;
    assign bus.we_i      = r_we_i;
    assign bus.waddr_i   = r_waddr_i;
    assign bus.wdata_i   = r_wdata_i;
    assign bus.we_w      = r_we_w;
    assign bus.waddr_w   = r_waddr_w;
    assign bus.wdata_w   = r_wdata_w;
    assign bus.mnt       = r_mnt;
endmodule
